// File: rtl/cpu_types_pkg.sv
// Shared CPU constants and types for the branch target predictor.
package cpu_types_pkg;
    localparam int BTB_ENTRIES = 16;
    localparam int BTB_CTR_W   = 2;
    localparam int BTB_PC_W    = 32;
    localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int BTB_TAG_W   = BTB_PC_W - BTB_IDX_W - 2;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_PC_W-1:0]  target;
    } btb_entry_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with synchronous load and asynchronous reset value.
module sat_counter #(
    parameter int               WIDTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_cnt
);
    logic [WIDTH-1:0] r_cnt;

    // Load beats inc/dec; inc and dec hold at their respective limits.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            if (r_cnt != '1) r_cnt <= r_cnt + WIDTH'(1);
        end else if (i_dec) begin
            if (r_cnt != '0) r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/branch_target_predictor.sv
// Flip-flop BTB with per-entry saturating direction counters, EX-stage training,
// misprediction detection and branch/mispredict statistics.
module branch_target_predictor
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int CTR_W   = BTB_CTR_W,
    parameter int PC_W    = BTB_PC_W
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_en,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_target,
    input  logic            inval_all,
    output logic            mispredict,
    output logic [PC_W-1:0] correct_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [PC_W-1:0]    r_target [ENTRIES];
    logic [CTR_W-1:0]   w_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_lidx, w_uidx;
    logic [TAG_W-1:0] w_ltag, w_utag;
    logic             w_upd, w_wr, w_uhit;

    assign w_lidx = lookup_pc[IDX_W+1:2];
    assign w_ltag = lookup_pc[PC_W-1:IDX_W+2];
    assign w_uidx = upd_pc[IDX_W+1:2];
    assign w_utag = upd_pc[PC_W-1:IDX_W+2];

    assign pred_hit    = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
    assign pred_taken  = pred_hit && w_ctr[w_lidx][CTR_W-1];
    assign pred_target = pred_taken ? r_target[w_lidx] : lookup_pc + PC_W'(4);

    assign mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                                      (upd_taken && (upd_target != upd_pred_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);

    // Invalidation pre-empts array writes but not the statistics.
    assign w_upd  = upd_en && upd_valid;
    assign w_wr   = w_upd && !inval_all;
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (inval_all) begin
            r_valid <= '0;
        end else if (w_wr && upd_taken) begin
            r_valid[w_uidx]  <= 1'b1;
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= upd_target;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic w_sel;
        assign w_sel = w_wr && (w_uidx == IDX_W'(g));

        sat_counter #(.WIDTH(CTR_W), .RST_VAL(CTR_WNT)) u_ctr (
            .i_clk      (CLK),
            .i_rst      (RST),
            .i_load     (inval_all || (w_sel && !w_uhit && upd_taken)),
            .i_load_val (inval_all ? CTR_WNT : CTR_WT),
            .i_inc      (w_sel && w_uhit && upd_taken),
            .i_dec      (w_sel && w_uhit && !upd_taken),
            .o_cnt      (w_ctr[g])
        );
    end

    sat_counter #(.WIDTH(32), .RST_VAL('0)) u_stat_br (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_upd),
        .i_dec      (1'b0),
        .o_cnt      (stat_branches)
    );

    sat_counter #(.WIDTH(32), .RST_VAL('0)) u_stat_mp (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_upd && mispredict),
        .i_dec      (1'b0),
        .o_cnt      (stat_mispredicts)
    );
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor: directed plan plus randomized traffic.
module tb_branch_target_predictor;
    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int IDX_W   = 4;
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int CWT     = 1 << (CTR_W - 1);
    localparam int CWNT    = CWT - 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] lookup_pc = '0;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_en = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
    logic [31:0] upd_pc = '0, upd_target = '0, upd_pred_target = '0;
    logic        inval_all = 1'b0;
    logic        mispredict;
    logic [31:0] correct_pc, stat_branches, stat_mispredicts;

    branch_target_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .PC_W(32)) dut (
        .CLK(CLK), .RST(RST), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_en(upd_en), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .inval_all(inval_all),
        .mispredict(mispredict), .correct_pc(correct_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic        misp;
        logic [31:0] cpc;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    exp_t q[$];
    int n_total = 0;
    int n_pass  = 0;

    // Reference model: a table of entries keyed by PC index, counters as plain integers.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    longint      m_sb, m_sm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = CWNT;
        end
        m_sb = 0;
        m_sm = 0;
    endtask

    task automatic step(input logic [31:0] lpc, input bit en, input bit vld,
                        input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
                        input bit ptk, input logic [31:0] ptgt, input bit inv);
        exp_t e;
        int   li, ui;
        bit   uhit, misp;
        lookup_pc = lpc; upd_en = en; upd_valid = vld; upd_pc = upc; upd_taken = tk;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt; inval_all = inv;

        li       = idx_of(lpc);
        e.hit    = m_valid[li] && (m_tag[li] == tag_of(lpc));
        e.taken  = e.hit && (m_ctr[li] >= CWT);
        e.target = e.taken ? m_tgt[li] : lpc + 32'd4;
        misp     = vld && ((tk != ptk) || (tk && (tgt != ptgt)));
        e.misp   = misp;
        e.cpc    = tk ? tgt : upc + 32'd4;
        e.sb     = m_sb[31:0];
        e.sm     = m_sm[31:0];
        q.push_back(e);

        if (en && vld) begin
            if (m_sb < 64'hFFFF_FFFF) m_sb++;
            if (misp && m_sm < 64'hFFFF_FFFF) m_sm++;
        end
        if (inv) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = CWNT;
            end
        end else if (en && vld) begin
            ui   = idx_of(upc);
            uhit = m_valid[ui] && (m_tag[ui] == tag_of(upc));
            if (uhit) begin
                if (tk) begin
                    m_ctr[ui] = (m_ctr[ui] < CMAX) ? m_ctr[ui] + 1 : CMAX;
                    m_tgt[ui] = tgt;
                end else begin
                    m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                end
            end else if (tk) begin
                m_valid[ui] = 1'b1;
                m_tag[ui]   = tag_of(upc);
                m_tgt[ui]   = tgt;
                m_ctr[ui]   = CWT;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    task automatic rand_step();
        logic [31:0] upc, tgt, ptgt;
        bit          tk, ptk;
        upc  = rand_pc();
        tk   = 1'($urandom_range(0, 1));
        tgt  = rand_pc();
        ptk  = 1'($urandom_range(0, 1));
        ptgt = ($urandom_range(0, 2) == 0) ? rand_pc() : tgt;
        step(rand_pc(), $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
             upc, tk, tgt, ptk, ptgt, $urandom_range(0, 40) == 0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pred_hit",         32'(pred_hit),   32'(e.hit));
            chk("pred_taken",       32'(pred_taken), 32'(e.taken));
            chk("pred_target",      pred_target,     e.target);
            chk("mispredict",       32'(mispredict), 32'(e.misp));
            chk("correct_pc",       correct_pc,      e.cpc);
            chk("stat_branches",    stat_branches,   e.sb);
            chk("stat_mispredicts", stat_mispredicts, e.sm);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset state, then first allocation with a mispredict.
        step(32'h40, 1, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0);
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0);
        // Counter walk down to zero with saturation, then up to max.
        step(32'h40, 1, 1, 32'h40, 0, 32'h44,  1, 32'h100, 0);
        step(32'h40, 1, 1, 32'h40, 0, 32'h44,  0, 32'h44,  0);
        step(32'h40, 1, 1, 32'h40, 0, 32'h44,  0, 32'h44,  0);
        for (int i = 0; i < 4; i++) step(32'h40, 1, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
        step(32'h40, 1, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0);
        // Aliasing on index 0 with different tags.
        step(32'h40, 1, 1, 32'h80, 1, 32'h200, 0, 32'h84,  0);
        step(32'h80, 1, 1, 32'h40, 1, 32'h300, 1, 32'h300, 0);
        step(32'h80, 1, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0);
        step(32'h40, 1, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0);
        // Invalidate wins over a same-cycle update; stats still count it.
        step(32'h40, 1, 1, 32'h40, 1, 32'h100, 0, 32'h44,  1);
        step(32'h40, 1, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0);
        // Pipeline stalled: mispredict visible, no state change.
        step(32'h40, 0, 1, 32'h40, 1, 32'h500, 0, 32'h44,  0);
        step(32'h40, 1, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0);
        // PC wrap-around.
        step(32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 0);
        step(32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 1, 32'h0,  0, 32'h0,  0);
        step(32'hFFFF_FFFC, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);

        for (int i = 0; i < 400; i++) rand_step();

        // Asynchronous reset between clock edges, with an update still applied.
        #2 RST = 1'b1;
        #1;
        chk("async_rst pred_hit",      32'(pred_hit),   32'd0);
        chk("async_rst pred_taken",    32'(pred_taken), 32'd0);
        chk("async_rst pred_target",   pred_target,     lookup_pc + 32'd4);
        chk("async_rst stat_branches", stat_branches,   32'd0);
        chk("async_rst stat_misp",     stat_mispredicts, 32'd0);
        model_reset();
        @(posedge CLK);
        #1 RST = 1'b0;

        for (int i = 0; i < 100; i++) rand_step();
        @(posedge CLK);
        #1;
        if (q.size() != 0) chk("scoreboard_drain", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target buffer with saturating-counter direction prediction for the five-stage pipeline. It replaces the current "predict not-taken, flush IF/ID and ID/EX on every taken branch" policy. The block is looked up combinationally by the fetch stage with the current PC. It is trained at the EX stage, where branch and jump outcomes resolve. It also flags mispredictions and supplies the corrected PC to the PC mux and flush logic.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, ≥2; IDX_W = $clog2(ENTRIES)
- CTR_W, 2, width of each direction counter; ≥1
- PC_W, 32, PC and target width; TAG_W = PC_W − IDX_W − 2

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; asynchronous, active-high
- lookup_pc  in  PC_W  current fetch PC (pcif.PCOut)
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  pred_hit & counter MSB
- pred_target  out  PC_W  stored target when pred_taken, else lookup_pc+4
- upd_en  in  1  pipeline advancing this cycle (ihit); gates all state changes
- upd_valid  in  1  EX holds a branch or jump
- upd_pc  in  PC_W  PC of the EX instruction
- upd_taken  in  1  resolved direction
- upd_target  in  PC_W  resolved target
- upd_pred_taken  in  1  prediction carried down the pipeline with the instruction
- upd_pred_target  in  PC_W  predicted next PC carried down the pipeline
- inval_all  in  1  invalidate every entry
- mispredict  out  1  combinational misprediction flag
- correct_pc  out  PC_W  upd_taken ? upd_target : upd_pc+4
- stat_branches  out  32  count of resolved branches
- stat_mispredicts  out  32  count of mispredictions

## Operation
Indexing and lookup:
- index = pc[IDX_W+1:2]; tag = pc[PC_W−1:IDX_W+2].
- Lookup is purely combinational from the arrays: valid[], tag[], target[], ctr[].

Misprediction detection:
- mispredict = upd_valid & ((upd_taken ≠ upd_pred_taken) | (upd_taken & upd_target ≠ upd_pred_target)).
- The flag is independent of upd_en.

Update, at a rising edge with upd_en & upd_valid & !inval_all:
- Hit with taken: ctr increments, saturating at 2^CTR_W−1; target ← upd_target.
- Hit with not-taken: ctr decrements, saturating at 0; target unchanged.
- Miss with taken: allocate the entry (overwriting any prior occupant). valid←1, tag and target written, ctr ← 2^(CTR_W−1) (weakly taken).
- Miss with not-taken: no allocation and no state change.

Invalidation:
- inval_all with upd_en don't-care clears all valid bits and resets all ctr to 2^(CTR_W−1)−1 at the next edge.
- inval_all has priority over a same-cycle update. The statistics still count that update.

Statistics:
- stat_branches increments on upd_en & upd_valid.
- stat_mispredicts increments on upd_en & upd_valid & mispredict.
- Both counters saturate at 32'hFFFF_FFFF.

Reset (RST high, asynchronous):
- valid[]=0, ctr[]=2^(CTR_W−1)−1 (weakly not-taken), tag[]=0, target[]=0, both stat counters 0.
- Resulting outputs: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
- Reset asserted mid-update discards that update.

## Timing
- Lookup latency is 0 cycles; pred_* follow lookup_pc combinationally.
- Update latency is 1 cycle: a write at edge N is visible to lookups after edge N.
- Same-index lookup and update in one cycle: the lookup sees the pre-update contents; no bypass.
- mispredict and correct_pc are combinational on the upd_* inputs. The datapath uses them in the same cycle to redirect PC and flush IF/ID and ID/EX.
- upd_en low: arrays and statistics hold; outputs remain combinational.
- PC+4 and target arithmetic is modulo 2^PC_W; wrap-around from all-ones to 0 is legal.

## Structure
- Shared constants go in cpu_types_pkg: BTB_ENTRIES, BTB_CTR_W, and a btb_entry_t struct {valid, tag, target}.
- Natural sub-module: sat_counter (parametrised WIDTH, inc/dec/load, saturating), used for the per-entry ctr and for both statistics counters.
- Arrays are flip-flop based so they can be cleared in one cycle; no SRAM macro.
- Interface file: branch_predictor_if.vh, with modports bp, fetch and ex.

## Test plan
- Reset, then lookup_pc=0x40 → pred_hit=0, pred_taken=0, pred_target=0x44; both stats 0.
- Taken update at upd_pc=0x40, upd_target=0x100, upd_pred_taken=0 → mispredict=1, correct_pc=0x100. Next cycle, lookup 0x40 → hit, taken, target=0x100; stat_mispredicts=1.
- With ENTRIES=16, two not-taken updates on the 0x40 entry → ctr goes 2→1→0 and pred_taken=0. A third not-taken update leaves ctr at 0 (saturation). Three taken updates → ctr reaches 3 and saturates.
- Aliasing: a taken update at 0x80 then 0x40 with ENTRIES=16 shares index 0, differing tags. Lookup 0x80 → miss; lookup 0x40 → hit.
- Same cycle: inval_all=1 plus a taken update at 0x40 → after the edge, lookup 0x40 misses; stat_branches still increments.
- upd_en=0 with upd_valid=1 and a mispredicting update → mispredict=1 combinationally, but no array or stat change. Assert RST mid-sequence → all state returns to reset values immediately, without waiting for CLK.
